// File: rtl/display_scan_if.sv
// Bundle of the display controller's data inputs and registered drive outputs.
interface display_scan_if #(
  parameter int N_DIGITS = 4
);
  logic [4*N_DIGITS-1:0] data;
  logic [N_DIGITS-1:0]   dp;
  logic [N_DIGITS-1:0]   digit_en;
  logic [4:0]            bright;
  logic [6:0]            seg;
  logic                  dp_n;
  logic [N_DIGITS-1:0]   an;
  logic [2:0]            digit_idx;
  logic                  frame_start;

  // Producer of digit data / consumer of the display drive.
  modport master (
    output data, dp, digit_en, bright,
    input  seg, dp_n, an, digit_idx, frame_start
  );

  // The scan controller itself.
  modport slave (
    input  data, dp, digit_en, bright,
    output seg, dp_n, an, digit_idx, frame_start
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment scan controller with per-slot dead time and PWM
// brightness. Inputs are sampled once per frame; all outputs are registered.
module display_scan_ctrl #(
  parameter int N_DIGITS    = 4,
  parameter int STEP        = 2,
  parameter int BLANK_TICKS = 2
) (
  input  logic           clk_27k,
  input  logic           rst,
  display_scan_if.slave  bus
);

  localparam int DWELL = BLANK_TICKS + 16 * STEP;
  localparam int CW    = $clog2(DWELL);

  typedef enum logic [1:0] {ST_BLANK, ST_ON, ST_OFF} state_t;

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [2:0]            slot_q, slot_d;
  state_t                state_q, state_d;
  logic [4*N_DIGITS-1:0] data_snap_q, data_snap_d;
  logic [N_DIGITS-1:0]   dp_snap_q, dp_snap_d;
  logic [N_DIGITS-1:0]   en_snap_q, en_snap_d;
  logic [4:0]            bright_snap_q, bright_snap_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_n_q, dp_n_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic [2:0]            digit_idx_q, digit_idx_d;
  logic                  frame_start_q, frame_start_d;

  logic                  frame_tick;
  logic [N_DIGITS-1:0]   slot_sel;
  logic [3:0]            nibble;
  logic                  lit;
  logic                  dp_req;
  int                    cnt_next_i;
  int                    on_len_i;

  // Standard active-low hex font, segment order {a,b,c,d,e,f,g}.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  assign frame_tick = (cnt_q == '0) && (slot_q == 3'd0);

  // One-hot decode of the current slot, one bit per digit.
  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_sel
    assign slot_sel[gi] = (slot_q == 3'(gi));
  end

  // Tick/slot counters and the once-per-frame input snapshot.
  always_comb begin
    cnt_d         = cnt_q + 1'b1;
    slot_d        = slot_q;
    data_snap_d   = data_snap_q;
    dp_snap_d     = dp_snap_q;
    en_snap_d     = en_snap_q;
    bright_snap_d = bright_snap_q;
    if (cnt_q == CW'(DWELL - 1)) begin
      cnt_d  = '0;
      slot_d = (slot_q == 3'(N_DIGITS - 1)) ? 3'd0 : slot_q + 3'd1;
    end
    if (frame_tick) begin
      data_snap_d   = bus.data;
      dp_snap_d     = bus.dp;
      en_snap_d     = bus.digit_en;
      // Saturate here so the PWM compare never sees a value above 16.
      bright_snap_d = (bus.bright > 5'd16) ? 5'd16 : bus.bright;
    end
  end

  // Slot phase FSM: tracks the phase that belongs to the next cnt value, so
  // it uses the brightness that will be in force after this edge.
  always_comb begin
    cnt_next_i = 32'(cnt_d);
    on_len_i   = 32'(bright_snap_d) * STEP;
    state_d    = state_q;
    if (cnt_d == '0) begin
      state_d = ST_BLANK;
    end else begin
      case (state_q)
        ST_BLANK: if (cnt_next_i >= BLANK_TICKS)
                    state_d = (on_len_i > 0) ? ST_ON : ST_OFF;
        ST_ON:    if (cnt_next_i - BLANK_TICKS >= on_len_i)
                    state_d = ST_OFF;
        ST_OFF:   state_d = ST_OFF;
        default:  state_d = ST_BLANK;
      endcase
    end
  end

  // Output decode from the current slot, tick and phase; registered below.
  always_comb begin
    nibble = 4'h0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (slot_sel[i]) nibble = data_snap_q[4*i +: 4];
    end
    lit           = (state_q == ST_ON) && |(slot_sel & en_snap_q);
    dp_req        = |(slot_sel & dp_snap_q);
    an_d          = lit ? ~slot_sel : '1;
    seg_d         = lit ? hex7(nibble) : 7'b1111111;
    dp_n_d        = lit ? ~dp_req : 1'b1;
    digit_idx_d   = slot_q;
    frame_start_d = frame_tick;
  end

  // State and output registers; reset forces the display dark at once.
  always_ff @(posedge clk_27k or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      slot_q        <= 3'd0;
      state_q       <= ST_BLANK;
      data_snap_q   <= '0;
      dp_snap_q     <= '0;
      en_snap_q     <= '0;
      bright_snap_q <= 5'd0;
      seg_q         <= 7'b1111111;
      dp_n_q        <= 1'b1;
      an_q          <= '1;
      digit_idx_q   <= 3'd0;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      slot_q        <= slot_d;
      state_q       <= state_d;
      data_snap_q   <= data_snap_d;
      dp_snap_q     <= dp_snap_d;
      en_snap_q     <= en_snap_d;
      bright_snap_q <= bright_snap_d;
      seg_q         <= seg_d;
      dp_n_q        <= dp_n_d;
      an_q          <= an_d;
      digit_idx_q   <= digit_idx_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.seg         = seg_q;
  assign bus.dp_n        = dp_n_q;
  assign bus.an          = an_q;
  assign bus.digit_idx   = digit_idx_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench: stimulus pushes the expected per-cycle display drive,
// monitors pop and compare on every falling edge.
module tb_display_scan_ctrl;

  typedef struct {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp_n;
    logic [2:0] idx;
    logic       fs;
  } exp_t;

  logic clk_27k = 1'b0;
  logic rst     = 1'b1;
  int   n_cmp   = 0;
  int   n_bad   = 0;
  exp_t q4[$];
  exp_t q1[$];

  logic [6:0] hex_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  display_scan_if #(.N_DIGITS(4)) bus4 ();
  display_scan_if #(.N_DIGITS(1)) bus1 ();

  display_scan_ctrl #(.N_DIGITS(4), .STEP(2), .BLANK_TICKS(2)) dut4 (
    .clk_27k (clk_27k),
    .rst     (rst),
    .bus     (bus4)
  );

  display_scan_ctrl #(.N_DIGITS(1), .STEP(1), .BLANK_TICKS(1)) dut1 (
    .clk_27k (clk_27k),
    .rst     (rst),
    .bus     (bus1)
  );

  always #5 clk_27k = ~clk_27k;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end else begin
      $display("ok   %s: %h at %0t", name, act, $time);
    end
  endtask

  // Expected drive for slot s, tick c (hand-derived blank/on windows).
  function automatic exp_t mk(input int s, input int c, input logic [15:0] d,
                              input logic [3:0] en, input logic [3:0] dpv,
                              input int b, input int blank, input int step);
    exp_t e;
    logic [3:0] nib;
    logic on;
    nib    = d[4*s +: 4];
    on     = en[s[1:0]] && (c >= blank) && ((c - blank) < b * step);
    e.an   = on ? ~(8'h01 << s) : 8'hFF;
    e.seg  = on ? hex_tab[nib] : 7'b1111111;
    e.dp_n = on ? ~dpv[s[1:0]] : 1'b1;
    e.idx  = 3'(s);
    e.fs   = (s == 0) && (c == 0);
    return e;
  endfunction

  // Queue one 4-digit frame (34-tick slots), truncated to 'limit' cycles.
  task automatic push4(input logic [15:0] d, input logic [3:0] en,
                       input logic [3:0] dpv, input int b, input int limit);
    int n = 0;
    for (int s = 0; s < 4; s++)
      for (int c = 0; c < 34; c++) begin
        if (n < limit) q4.push_back(mk(s, c, d, en, dpv, b, 2, 2));
        n++;
      end
  endtask

  // Reset, check the reset drive, then release just before a rising edge.
  task automatic restart();
    exp_t e;
    rst = 1'b1;
    @(posedge clk_27k); #1;
    e.an = 8'hFF; e.seg = 7'b1111111; e.dp_n = 1'b1; e.idx = 3'd0; e.fs = 1'b0;
    q4.push_back(e);
    @(negedge clk_27k); #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while ((q4.size() > 0 || q1.size() > 0) && g < 3000) begin
      @(negedge clk_27k); #1;
      g++;
    end
    if (g >= 3000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d entries left, required 0", q4.size() + q1.size());
      q4.delete();
      q1.delete();
    end
  endtask

  // Monitor for the 4-digit instance.
  always @(negedge clk_27k) begin
    if (q4.size() > 0) begin
      exp_t e;
      e = q4.pop_front();
      n_cmp++;
      if ({bus4.an, bus4.seg, bus4.dp_n, bus4.digit_idx, bus4.frame_start} !==
          {e.an[3:0], e.seg, e.dp_n, e.idx, e.fs}) begin
        n_bad++;
        $display("FAIL out4 @%0t: got an=%b seg=%b dp_n=%b idx=%0d fs=%b, expected an=%b seg=%b dp_n=%b idx=%0d fs=%b",
                 $time, bus4.an, bus4.seg, bus4.dp_n, bus4.digit_idx, bus4.frame_start,
                 e.an[3:0], e.seg, e.dp_n, e.idx, e.fs);
      end
    end
  end

  // Monitor for the single-digit instance.
  always @(negedge clk_27k) begin
    if (q1.size() > 0) begin
      exp_t e;
      e = q1.pop_front();
      n_cmp++;
      if ({bus1.an, bus1.seg, bus1.dp_n, bus1.digit_idx, bus1.frame_start} !==
          {e.an[0], e.seg, e.dp_n, e.idx, e.fs}) begin
        n_bad++;
        $display("FAIL out1 @%0t: got an=%b seg=%b dp_n=%b idx=%0d fs=%b, expected an=%b seg=%b dp_n=%b idx=%0d fs=%b",
                 $time, bus1.an, bus1.seg, bus1.dp_n, bus1.digit_idx, bus1.frame_start,
                 e.an[0], e.seg, e.dp_n, e.idx, e.fs);
      end
    end
  end

  initial begin
    bus4.data = 16'h4321; bus4.dp = 4'h0; bus4.digit_en = 4'hF; bus4.bright = 5'd16;
    bus1.data = 4'hA;     bus1.dp = 1'b1; bus1.digit_en = 1'b1; bus1.bright = 5'd16;

    // Full brightness, two frames: 2 blank + 32 on per slot, 136-cycle frame.
    restart();
    push4(16'h4321, 4'hF, 4'h0, 16, 2 * 136);
    drain();
    $display("txn full_bright done, %0d compared", n_cmp);

    // Half brightness: 16 of 34 ticks lit.
    bus4.bright = 5'd8;
    restart();
    push4(16'h4321, 4'hF, 4'h0, 8, 136);
    drain();
    $display("txn bright8 done, %0d compared", n_cmp);

    // Zero brightness: display stays dark but timing runs.
    bus4.bright = 5'd0;
    restart();
    push4(16'h4321, 4'hF, 4'h0, 0, 136);
    drain();
    $display("txn bright0 done, %0d compared", n_cmp);

    // Out-of-range brightness saturates to 16.
    bus4.bright = 5'd31;
    restart();
    push4(16'h4321, 4'hF, 4'h0, 16, 136);
    drain();
    $display("txn bright31 done, %0d compared", n_cmp);

    // Disabled digits keep their slots dark; decimal point on slot 1.
    bus4.bright = 5'd16; bus4.digit_en = 4'b1010; bus4.dp = 4'b0010;
    restart();
    push4(16'h4321, 4'b1010, 4'b0010, 16, 136);
    drain();
    $display("txn digit_en_dp done, %0d compared", n_cmp);

    // Mid-frame data change only shows up at the next frame.
    bus4.digit_en = 4'hF; bus4.dp = 4'h0; bus4.data = 16'h0000;
    restart();
    push4(16'h0000, 4'hF, 4'h0, 16, 136);
    push4(16'hFFFF, 4'hF, 4'h0, 16, 136);
    repeat (80) @(posedge clk_27k);
    #1 bus4.data = 16'hFFFF;
    drain();
    $display("txn midframe_data done, %0d compared", n_cmp);

    // Reset during slot 3 ON: display goes dark in the same cycle.
    bus4.data = 16'h4321;
    restart();
    push4(16'h4321, 4'hF, 4'h0, 16, 3 * 34 + 10);
    drain();
    chk("an_before_rst", 32'(bus4.an), 32'h7);
    rst = 1'b1;
    #1;
    chk("an_async_rst", 32'(bus4.an), 32'hF);
    chk("seg_async_rst", 32'(bus4.seg), 32'h7F);
    chk("dp_n_async_rst", 32'(bus4.dp_n), 32'h1);
    chk("idx_async_rst", 32'(bus4.digit_idx), 32'h0);
    restart();
    push4(16'h4321, 4'hF, 4'h0, 16, 136);
    drain();
    $display("txn rst_mid_on done, %0d compared", n_cmp);

    // Single digit, STEP=1, BLANK_TICKS=1: 17-tick frame, 1 blank + 16 on.
    restart();
    for (int f = 0; f < 3; f++)
      for (int c = 0; c < 17; c++)
        q1.push_back(mk(0, c, 16'h000A, 4'h1, 4'h1, 16, 1, 1));
    drain();
    $display("txn single_digit done, %0d compared", n_cmp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
